mem_access_unit: RTL and testbench

Load/store initiator between the CPU execute stage and the asynchronous single-port data RAM (32-bit word-indexed, level-sensitive write enable). Accepts one RV32 load/store per handshake, converts byte addresses to word indices, performs sub-word stores by read-modify-write, and sign- or zero-extends sub-word loads. Every RAM-facing signal is driven from a flop, so the write enable is glitch-free and never changes in the same cycle as the address or write data.

---
 rtl/mem_access_pkg.sv | 53 +++++
 rtl/mem_lane_align.sv | 55 +++++
 rtl/mem_access_unit.sv | 165 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Purpose : shared RV32 width codes, unit state encoding and request checks
//           for the data-RAM load/store initiator.
// Latency : n/a (declarations and pure functions only).
// Backpr. : n/a.
// Contents: F3_* width codes, mem_state_t, is_misaligned(), is_legal_funct3().
package mem_access_pkg;

  // RV32 load/store width codes (funct3 field).
  localparam logic [2:0] F3_B  = 3'b000;  // LB / SB
  localparam logic [2:0] F3_H  = 3'b001;  // LH / SH
  localparam logic [2:0] F3_W  = 3'b010;  // LW / SW
  localparam logic [2:0] F3_BU = 3'b100;  // LBU
  localparam logic [2:0] F3_HU = 3'b101;  // LHU

  // Unit sequencing. Every path starts in IDLE and passes through RESP,
  // which gives the one-cycle completion pulse and the write-enable hold.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    SETUP = 3'd2,
    WRITE = 3'd3,
    RESP  = 3'd4
  } mem_state_t;

  // Halfwords must sit on an even byte, words on a multiple of four.
  // Byte accesses and unknown codes never count as misaligned here; unknown
  // codes are rejected separately by is_legal_funct3().
  function automatic logic is_misaligned(input logic [2:0] funct3,
                                         input logic [1:0] offset);
    logic mis;
    mis = 1'b0;
    case (funct3)
      F3_H, F3_HU: mis = offset[0];
      F3_W:        mis = (offset != 2'b00);
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

  // Stores have no unsigned variants; loads accept the five RV32 codes.
  function automatic logic is_legal_funct3(input logic [2:0] funct3,
                                           input logic       write);
    logic ok;
    ok = 1'b0;
    case (funct3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = !write;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Purpose : byte/halfword lane steering for a 32-bit word RAM: load extract
//           with sign/zero extension, and sub-word store merge.
// Latency : combinational, 0 cycles.
// Backpr. : none; pure function of its inputs.
// Ports   : i_funct3  width code of the access
//           i_offset  byte offset within the word (addr[1:0])
//           i_word    full word as read from the RAM
//           i_wdata   right-aligned store data (only 16 bits ever needed)
//           o_load    extracted and extended load result
//           o_merged  i_word with the store lanes replaced
module mem_lane_align
  import mem_access_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       i_funct3,
  input  logic [1:0]       i_offset,
  input  logic [WIDTH-1:0] i_word,
  input  logic [15:0]      i_wdata,
  output logic [WIDTH-1:0] o_load,
  output logic [WIDTH-1:0] o_merged
);

  logic [4:0]       w_shamt;
  logic [WIDTH-1:0] w_shifted;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [WIDTH-1:0] w_lane_mask;
  logic [WIDTH-1:0] w_lane_data;

  // Byte lane n occupies bits [8n+7:8n], so the lane shift is offset*8.
  assign w_shamt   = {i_offset, 3'b000};
  assign w_shifted = i_word >> w_shamt;
  assign w_byte    = w_shifted[7:0];
  assign w_half    = w_shifted[15:0];

  always_comb begin
    o_load = i_word;
    case (i_funct3)
      F3_B:    o_load = {{(WIDTH-8){w_byte[7]}}, w_byte};
      F3_BU:   o_load = {{(WIDTH-8){1'b0}}, w_byte};
      F3_H:    o_load = {{(WIDTH-16){w_half[15]}}, w_half};
      F3_HU:   o_load = {{(WIDTH-16){1'b0}}, w_half};
      default: o_load = i_word;
    endcase
  end

  // funct3[0] separates SH (001) from SB (000); SW never uses the merge.
  assign w_lane_mask = i_funct3[0] ? WIDTH'(16'hFFFF) : WIDTH'(8'hFF);
  assign w_lane_data = i_funct3[0] ? WIDTH'(i_wdata) : WIDTH'(i_wdata[7:0]);

  assign o_merged = (i_word & ~(w_lane_mask << w_shamt))
                  | (w_lane_data << w_shamt);

endmodule

// File: rtl/mem_access_unit.sv
// Purpose : one-at-a-time RV32 load/store initiator in front of an async
//           single-port word RAM; sub-word stores done as read-modify-write.
// Latency : accept=cycle 0; rsp_valid at 2 (load), 3 (SW), 4 (SB/SH), 1 (error).
// Backpr. : req_ready only in IDLE; rsp_valid is a single-cycle pulse that
//           cannot be stalled.
// Ports   : clock/nreset        clock, async active-low reset
//           req_*               request handshake, type, address, store data
//           rsp_*               completion pulse, load result, error flag
//           ram_address/wdata   registered word index and full write word
//           ram_enw             registered write enable, high only in WRITE
//           ram_rdata           combinational read data for ram_address
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2048
) (
  input  logic             clock,
  input  logic             nreset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [2:0]       req_funct3,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_error,
  output logic [WIDTH-1:0] ram_address,
  output logic [WIDTH-1:0] ram_wdata,
  output logic             ram_enw,
  input  logic [WIDTH-1:0] ram_rdata
);

  mem_state_t       r_state;
  logic [2:0]       r_funct3;
  logic [1:0]       r_offset;
  logic [15:0]      r_wdata;     // only the sub-word store lanes are kept
  logic             r_write;
  logic             r_err;
  logic [WIDTH-1:0] r_rsp_data;
  logic [WIDTH-1:0] r_ram_address;
  logic [WIDTH-1:0] r_ram_wdata;
  logic             r_ram_enw;

  logic [WIDTH-1:0] w_word_idx;
  logic             w_out_of_range;
  logic             w_req_err;
  logic             w_accept;
  logic [WIDTH-1:0] w_load;
  logic [WIDTH-1:0] w_merged;

  // ---------------------------------------------------------------------------
  // Request decode (IDLE only)
  // ---------------------------------------------------------------------------
  assign w_word_idx     = req_addr >> 2;
  assign w_out_of_range = (w_word_idx >= WIDTH'(DEPTH));
  assign w_req_err      = is_misaligned(req_funct3, req_addr[1:0])
                        | w_out_of_range
                        | !is_legal_funct3(req_funct3, req_write);

  assign w_accept = req_valid && (r_state == IDLE);

  // ---------------------------------------------------------------------------
  // Lane steering on the word currently presented by the RAM
  // ---------------------------------------------------------------------------
  mem_lane_align #(
    .WIDTH (WIDTH)
  ) u_lane_align (
    .i_funct3 (r_funct3),
    .i_offset (r_offset),
    .i_word   (ram_rdata),
    .i_wdata  (r_wdata),
    .o_load   (w_load),
    .o_merged (w_merged)
  );

  // ---------------------------------------------------------------------------
  // Sequencer and RAM-facing registers
  //
  // ram_address / ram_wdata are only loaded on accept or when leaving READ
  // for a store, and always with SETUP in between and RESP after, so they are
  // stable for a full cycle on each side of the one-cycle write enable.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      r_state       <= IDLE;
      r_funct3      <= F3_B;
      r_offset      <= 2'b00;
      r_wdata       <= '0;
      r_write       <= 1'b0;
      r_err         <= 1'b0;
      r_rsp_data    <= '0;
      r_ram_address <= '0;
      r_ram_wdata   <= '0;
      r_ram_enw     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_funct3      <= req_funct3;
            r_offset      <= req_addr[1:0];
            r_wdata       <= req_wdata[15:0];
            r_write       <= req_write;
            r_err         <= w_req_err;
            r_rsp_data    <= '0;
            r_ram_address <= w_word_idx;
            if (w_req_err) begin
              r_state <= RESP;
            end else if (req_write && (req_funct3 == F3_W)) begin
              // Full-word store needs no read; data goes straight out.
              r_ram_wdata <= req_wdata;
              r_state     <= SETUP;
            end else begin
              r_state <= READ;
            end
          end
        end

        READ: begin
          if (r_write) begin
            r_ram_wdata <= w_merged;
            r_state     <= SETUP;
          end else begin
            r_rsp_data <= w_load;
            r_state    <= RESP;
          end
        end

        SETUP: begin
          r_ram_enw <= 1'b1;
          r_state   <= WRITE;
        end

        WRITE: begin
          r_ram_enw <= 1'b0;
          r_state   <= RESP;
        end

        RESP: begin
          r_state <= IDLE;
        end

        default: begin
          r_ram_enw <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign req_ready   = (r_state == IDLE);
  assign rsp_valid   = (r_state == RESP);
  // Result fields are only meaningful alongside the completion pulse.
  assign rsp_error   = rsp_valid & r_err;
  assign rsp_data    = rsp_valid ? r_rsp_data : '0;

  assign ram_address = r_ram_address;
  assign ram_wdata   = r_ram_wdata;
  assign ram_enw     = r_ram_enw;

endmodule

// File: tb/tb_mem_access_unit.sv
// Purpose : self-checking bench for mem_access_unit with a behavioural
//           async word RAM and a response scoreboard.
// Latency : checks completion latency of every request against its class.
// Backpr. : requests wait for req_ready; responses are never stalled.
module tb_mem_access_unit;
  import mem_access_pkg::*;

  localparam int WIDTH = 32;
  localparam int DEPTH = 2048;

  logic             clock = 1'b0;
  logic             nreset = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic             req_write = 1'b0;
  logic [2:0]       req_funct3 = 3'b000;
  logic [WIDTH-1:0] req_addr = '0;
  logic [WIDTH-1:0] req_wdata = '0;
  logic             rsp_valid;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_error;
  logic [WIDTH-1:0] ram_address;
  logic [WIDTH-1:0] ram_wdata;
  logic             ram_enw;
  logic [WIDTH-1:0] ram_rdata;

  mem_access_unit #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clock       (clock),
    .nreset      (nreset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_funct3  (req_funct3),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_error   (rsp_error),
    .ram_address (ram_address),
    .ram_wdata   (ram_wdata),
    .ram_enw     (ram_enw),
    .ram_rdata   (ram_rdata)
  );

  always #5 clock = ~clock;

  // Behavioural RAM: async read, level-sensitive write.
  logic [31:0] mem [0:DEPTH-1];
  assign ram_rdata = (ram_address < DEPTH) ? mem[ram_address[10:0]] : 32'h0;
  always @(ram_enw or ram_address or ram_wdata)
    if (ram_enw && (ram_address < DEPTH)) mem[ram_address[10:0]] = ram_wdata;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          acc;
    int          lat;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          enw_cnt = 0;
  int          last_enw_cyc = 0;
  int          rsp_cnt = 0;
  int          last_acc = 0;
  bit          mon_en = 1'b1;
  logic        prev_enw = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [31:0] prev_wdata = '0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Response scoreboard and RAM write-enable monitor, sampled mid-cycle.
  always @(negedge clock) begin
    if (nreset) begin
      if (rsp_valid) begin
        rsp_cnt++;
        if (sb.size() == 0) begin
          chk("rsp_pending_count", 32'(sb.size()), 32'd1);
        end else begin
          mon_e = sb.pop_front();
          chk({mon_e.tag, "_data"}, rsp_data, mon_e.data);
          chk({mon_e.tag, "_error"}, 32'(rsp_error), 32'(mon_e.err));
          chk({mon_e.tag, "_latency"}, 32'(cyc - mon_e.acc), 32'(mon_e.lat));
        end
      end
      if (mon_en) begin
        if (ram_enw && !prev_enw) begin
          enw_cnt++;
          last_enw_cyc = cyc;
          chk("enw_addr_setup", ram_address, prev_addr);
          chk("enw_wdata_setup", ram_wdata, prev_wdata);
        end
        if (!ram_enw && prev_enw) begin
          chk("enw_width", 32'(cyc - last_enw_cyc), 32'd1);
          chk("enw_addr_hold", ram_address, prev_addr);
          chk("enw_wdata_hold", ram_wdata, prev_wdata);
        end
      end
    end
    prev_enw   = ram_enw;
    prev_addr  = ram_address;
    prev_wdata = ram_wdata;
  end

  // Present a request, wait for acceptance, push the expected response.
  // Returns just after the accept edge with req_valid still asserted.
  task automatic issue(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_data,
                       input logic exp_err, input int lat, input string tag);
    int n;
    exp_t e;
    @(negedge clock);
    req_write  = wr;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    req_valid  = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!req_ready) begin
      chk({tag, "_accept_timeout"}, 32'(req_ready), 32'd1);
    end else begin
      e.data = exp_data; e.err = exp_err; e.acc = cyc; e.lat = lat; e.tag = tag;
      sb.push_back(e);
      last_acc = cyc;
    end
    @(posedge clock);
  endtask

  task automatic drain();
    int n;
    @(negedge clock);
    req_valid = 1'b0;
    n = 0;
    while (sb.size() > 0 && n < 60) begin
      @(negedge clock);
      n++;
    end
    chk("drain_pending", 32'(sb.size()), 32'd0);
    @(negedge clock);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int e0, r0, a0, a1, a2;
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h0;

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_error", 32'(rsp_error), 32'd0);
    chk("rst_ram_address", ram_address, 32'd0);
    chk("rst_ram_wdata", ram_wdata, 32'd0);
    chk("rst_ram_enw", 32'(ram_enw), 32'd0);
    nreset = 1'b1;

    // Full-word store then load
    e0 = enw_cnt;
    issue(1'b1, F3_W, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 3, "sw10");
    a0 = last_acc;
    drain();
    chk("sw10_enw_count", 32'(enw_cnt - e0), 32'd1);
    chk("sw10_enw_cycle", 32'(last_enw_cyc - a0), 32'd2);
    chk("sw10_ram_address", ram_address, 32'd4);
    chk("sw10_mem", mem[4], 32'hDEADBEEF);
    issue(1'b0, F3_W, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, "lw10");
    drain();

    // Byte store and signed/unsigned byte loads
    issue(1'b1, F3_B, 32'h11, 32'h00000080, 32'h0, 1'b0, 4, "sb11");
    drain();
    chk("sb11_mem", mem[4], 32'hDEAD80EF);
    issue(1'b0, F3_B,  32'h11, 32'h0, 32'hFFFFFF80, 1'b0, 2, "lb11");
    issue(1'b0, F3_BU, 32'h11, 32'h0, 32'h00000080, 1'b0, 2, "lbu11");
    drain();

    // Halfword store and halfword/byte loads
    issue(1'b1, F3_H, 32'h12, 32'hFFFF1234, 32'h0, 1'b0, 4, "sh12");
    drain();
    chk("sh12_mem", mem[4], 32'h123480EF);
    issue(1'b0, F3_H,  32'h12, 32'h0, 32'h00001234, 1'b0, 2, "lh12");
    issue(1'b0, F3_H,  32'h10, 32'h0, 32'hFFFF80EF, 1'b0, 2, "lh10");
    issue(1'b0, F3_HU, 32'h10, 32'h0, 32'h000080EF, 1'b0, 2, "lhu10");
    issue(1'b0, F3_B,  32'h13, 32'h0, 32'h00000012, 1'b0, 2, "lb13");
    drain();

    // Error requests: no RAM write, response one cycle after accept
    e0 = enw_cnt;
    issue(1'b0, F3_W,   32'h13,   32'h0,        32'h0, 1'b1, 1, "lw13_err");
    issue(1'b1, F3_H,   32'h11,   32'h0000AAAA, 32'h0, 1'b1, 1, "sh11_err");
    issue(1'b0, F3_W,   32'h2000, 32'h0,        32'h0, 1'b1, 1, "lw2000_err");
    issue(1'b1, F3_BU,  32'h10,   32'h00000055, 32'h0, 1'b1, 1, "sbu_err");
    issue(1'b0, 3'b011, 32'h10,   32'h0,        32'h0, 1'b1, 1, "ld011_err");
    drain();
    chk("err_enw_count", 32'(enw_cnt - e0), 32'd0);
    chk("err_mem", mem[4], 32'h123480EF);

    // Reset asserted during WRITE of a full-word store
    issue(1'b1, F3_W, 32'h40, 32'hCAFEF00D, 32'h0, 1'b0, 3, "sw40_rst");
    @(negedge clock);
    req_valid = 1'b0;
    @(posedge clock);
    #2;
    chk("rst_mid_enw_high", 32'(ram_enw), 32'd1);
    mon_en = 1'b0;
    r0 = rsp_cnt;
    nreset = 1'b0;
    #1;
    chk("rst_mid_enw_async", 32'(ram_enw), 32'd0);
    sb.delete();
    repeat (2) @(negedge clock);
    nreset = 1'b1;
    repeat (4) @(negedge clock);
    chk("rst_mid_no_rsp", 32'(rsp_cnt - r0), 32'd0);
    chk("rst_mid_ready", 32'(req_ready), 32'd1);
    mon_en = 1'b1;
    issue(1'b0, F3_W, 32'h10, 32'h0, 32'h123480EF, 1'b0, 2, "lw_after_rst");
    drain();

    // Three stores queued with req_valid held high
    e0 = enw_cnt;
    issue(1'b1, F3_W, 32'h20, 32'h11111111, 32'h0, 1'b0, 3, "swq0");
    a0 = last_acc;
    issue(1'b1, F3_W, 32'h24, 32'h22222222, 32'h0, 1'b0, 3, "swq1");
    a1 = last_acc;
    issue(1'b1, F3_W, 32'h28, 32'h33333333, 32'h0, 1'b0, 3, "swq2");
    a2 = last_acc;
    drain();
    chk("swq_spacing01", 32'(a1 - a0), 32'd4);
    chk("swq_spacing12", 32'(a2 - a1), 32'd4);
    chk("swq_enw_count", 32'(enw_cnt - e0), 32'd3);
    chk("swq_mem8", mem[8], 32'h11111111);
    chk("swq_mem9", mem[9], 32'h22222222);
    chk("swq_mem10", mem[10], 32'h33333333);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
